// File: rtl/sequential_divider_constant_time.sv
// sequential_divider_constant_time
//   Constant-time restoring divider. Produces one quotient bit every two
//   cycles (SHIFT then SUB), so latency is 2*WIDTH+2 cycles from the start
//   edge regardless of operand values, including a zero divisor.
//
// Ports
//   clk           clock, all state changes on rising edge
//   rst           synchronous active-low reset
//   start         request, honoured only when idle
//   dividend      unsigned dividend, captured at the end of the INIT cycle
//   divisor       unsigned divisor, captured at the end of the INIT cycle
//   quotient      registered quotient (Q register)
//   remainder     registered remainder (low WIDTH bits of R)
//   quotientDone  one-cycle pulse, results valid
//   divByZero     high together with quotientDone when divisor was 0
//   busy          high whenever an operation is in flight
//
// state   | meaning
// --------+--------------------------------------------------------------
// START   | idle, waiting for start
// INIT    | load Q <= dividend, D <= divisor, R <= 0, bit counter <= WIDTH-1
// SHIFT   | {R,Q} <= {R,Q} << 1
// SUB     | subtract D from R when R >= D, set Q[0]; count down bit index
// FINAL   | results valid, quotientDone pulse
module sequential_divider_constant_time #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             quotientDone,
  output logic             divByZero,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_START = 3'd0,
    S_INIT  = 3'd1,
    S_SHIFT = 3'd2,
    S_SUB   = 3'd3,
    S_FINAL = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    bit_cnt_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH:0]   r_q;

  // Compare and subtract at WIDTH+1 bits: after SHIFT, R can exceed any
  // WIDTH-bit divisor, and the subtraction must never wrap.
  logic [WIDTH:0] d_ext;
  logic [WIDTH:0] r_sub;
  logic           r_ge_d;

  assign d_ext  = {1'b0, d_q};
  assign r_sub  = r_q - d_ext;
  assign r_ge_d = (r_q >= d_ext);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_START: if (start) state_d = S_INIT;
      S_INIT:  state_d = S_SHIFT;
      S_SHIFT: state_d = S_SUB;
      S_SUB:   state_d = (bit_cnt_q == '0) ? S_FINAL : S_SHIFT;
      S_FINAL: state_d = S_START;
      default: state_d = S_START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_START;
      bit_cnt_q <= '0;
      q_q       <= '0;
      d_q       <= '0;
      r_q       <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_INIT: begin
          q_q       <= dividend;
          d_q       <= divisor;
          r_q       <= '0;
          bit_cnt_q <= CW'(WIDTH - 1);
        end
        S_SHIFT: begin
          {r_q, q_q} <= {r_q[WIDTH-1:0], q_q, 1'b0};
        end
        S_SUB: begin
          // Restore-by-skip: when R < D nothing is written.
          if (r_ge_d) begin
            r_q    <= r_sub;
            q_q[0] <= 1'b1;
          end
          if (bit_cnt_q != '0) bit_cnt_q <= bit_cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign quotient     = q_q;
  assign remainder    = r_q[WIDTH-1:0];
  assign busy         = (state_q != S_START);
  assign quotientDone = (state_q == S_FINAL);
  assign divByZero    = (state_q == S_FINAL) && (d_q == '0);

endmodule

// File: tb/tb_sequential_divider_constant_time.sv
module tb_sequential_divider_constant_time;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend, divisor;
  logic [W-1:0] quotient, remainder;
  logic         quotientDone, divByZero, busy;

  int tests = 0;
  int fails = 0;

  sequential_divider_constant_time #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder),
    .quotientDone(quotientDone), .divByZero(divByZero), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  vec_t vecs[8];

  // advance one rising edge and settle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer division; divide-by-zero gives all ones and the dividend.
  function automatic void ref_div(input int a, input int b, output int q, output int r, output int dz);
    if (b == 0) begin
      q = (1 << W) - 1; r = a; dz = 1;
    end else begin
      q = a / b; r = a % b; dz = 0;
    end
  endfunction

  // Run one operation from idle. Operands are scrambled and start is pulsed
  // while busy to confirm the in-flight op is unaffected.
  task automatic run_op(input int a, input int b, output int lat, output int q,
                        output int r, output int dz, output int bad);
    dividend = W'(a); divisor = W'(b); start = 1'b1;
    step();
    start = 1'b0;
    lat = -1; q = 0; r = 0; dz = 0; bad = 0;
    for (int n = 1; n <= 40; n++) begin
      if (!busy) bad++;
      if (divByZero && !quotientDone) bad++;
      if (quotientDone) begin
        lat = n; q = quotient; r = remainder; dz = divByZero;
        break;
      end
      step();
      if (n >= 1) begin
        dividend = W'($urandom);
        divisor  = W'($urandom);
      end
      start = (n == 3) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic op_and_check(input string tag, input int a, input int b);
    int lat, q, r, dz, bad, eq, er, edz;
    ref_div(a, b, eq, er, edz);
    run_op(a, b, lat, q, r, dz, bad);
    chk({tag, " latency"}, lat, 2*W + 2);
    chk({tag, " quotient"}, q, eq);
    chk({tag, " remainder"}, r, er);
    chk({tag, " divByZero"}, dz, edz);
    chk({tag, " busy/dz during op"}, bad, 0);
    step();
    chk({tag, " idle after"}, {quotientDone, divByZero, busy}, 0);
    chk({tag, " stable quotient"}, quotient, eq);
    chk({tag, " stable remainder"}, remainder, er);
  endtask

  initial begin
    int lat, q, r, dz, bad, eq, er, edz, pulses, cnt, errs;

    vecs[0] = '{4'd13, 4'd3, 4'd4,  4'd1, 1'b0};
    vecs[1] = '{4'd15, 4'd1, 4'd15, 4'd0, 1'b0};
    vecs[2] = '{4'd5,  4'd9, 4'd0,  4'd5, 1'b0};
    vecs[3] = '{4'd7,  4'd0, 4'd15, 4'd7, 1'b1};
    vecs[4] = '{4'd9,  4'd2, 4'd4,  4'd1, 1'b0};
    vecs[5] = '{4'd12, 4'd4, 4'd3,  4'd0, 1'b0};
    vecs[6] = '{4'd0,  4'd5, 4'd0,  4'd0, 1'b0};
    vecs[7] = '{4'd15, 4'd15, 4'd1, 4'd0, 1'b0};

    rst = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) step();
    chk("reset outputs", {quotient, remainder, quotientDone, divByZero, busy}, 0);
    rst = 1'b1;
    step();
    chk("idle after reset", {quotientDone, busy}, 0);

    // table-driven vectors with fixed expectations
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, lat, q, r, dz, bad);
      chk($sformatf("vec%0d latency", i), lat, 10);
      chk($sformatf("vec%0d quotient", i), q, vecs[i].q);
      chk($sformatf("vec%0d remainder", i), r, vecs[i].r);
      chk($sformatf("vec%0d divByZero", i), dz, vecs[i].dz);
      chk($sformatf("vec%0d busy/dz during op", i), bad, 0);
      step();
      chk($sformatf("vec%0d dz low after", i), {quotientDone, divByZero, busy}, 0);
    end

    // start held high: back-to-back ops every 11 cycles
    dividend = 4'd12; divisor = 4'd4; start = 1'b1;
    step();
    pulses = 0;
    for (int n = 1; n <= 45; n++) begin
      if (n == 5) begin dividend = 4'd15; divisor = 4'd1; end
      if (n == 6) begin dividend = 4'd12; divisor = 4'd4; end
      if (quotientDone) begin
        chk("held start pulse cycle", n, 10 + 11*pulses);
        chk("held start quotient", quotient, 3);
        chk("held start remainder", remainder, 0);
        pulses++;
        if (pulses == 3) begin
          start = 1'b0;
          break;
        end
      end
      step();
    end
    chk("held start pulse count", pulses, 3);
    step();
    chk("held start idle", busy, 0);

    // reset in the middle of an operation
    dividend = 4'd13; divisor = 4'd3; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    chk("mid-op busy before reset", busy, 1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("mid-op reset outputs", {quotient, remainder, quotientDone, divByZero, busy}, 0);
    cnt = 0;
    for (int n = 0; n < 15; n++) begin
      if (quotientDone || busy) cnt++;
      step();
    end
    chk("no partial result after reset", cnt, 0);
    op_and_check("post-reset 9/2", 9, 2);

    // exhaustive sweep against the reference model
    errs = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        ref_div(a, b, eq, er, edz);
        run_op(a, b, lat, q, r, dz, bad);
        if (lat != 10 || q != eq || r != er || dz != edz || bad != 0) begin
          errs++;
          $display("FAIL sweep %0d/%0d: got q=%0d r=%0d dz=%0d lat=%0d bad=%0d expected q=%0d r=%0d dz=%0d lat=10",
                   a, b, q, r, dz, lat, bad, eq, er, edz);
        end
        step();
      end
    end
    chk("exhaustive sweep errors", errs, 0);

    // random operations with full checks
    for (int k = 0; k < 12; k++) begin
      op_and_check($sformatf("rand%0d", k), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
